// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control FSM: states, opcodes,
// ALU/mux select codes and the bundled control word.
package multicycle_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_IF    = 4'd1,
    S_ID    = 4'd2,
    S_MADDR = 4'd3,
    S_MRD   = 4'd4,
    S_MWB   = 4'd5,
    S_MWR   = 4'd6,
    S_REX   = 4'd7,
    S_RWB   = 4'd8,
    S_IEX   = 4'd9,
    S_IWB   = 4'd10,
    S_BR    = 4'd11,
    S_JMP   = 4'd12,
    S_ILL   = 4'd13
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b010;
  localparam logic [2:0] ALU_SLT   = 3'b011;

  localparam logic [1:0] SRCB_RT     = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal;
  } ctrl_t;

  function automatic state_e id_dispatch(input logic [5:0] op);
    case (op)
      OP_RTYPE:         return S_REX;
      OP_ADDI, OP_SLTI: return S_IEX;
      OP_LW, OP_SW:     return S_MADDR;
      OP_BEQ, OP_BNE:   return S_BR;
      OP_J:             return S_JMP;
      default:          return S_ILL;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_ctrl_decode.sv
// Combinational state/opcode to datapath-control table. Everything is Moore
// except the IF load enables (gated by memory ready) and the BR PC write.
module multicycle_ctrl_decode
  import multicycle_ctrl_pkg::*;
(
  input  state_e      state_i,
  input  logic [5:0]  opcode_i,
  input  logic        zero_i,
  input  logic        mem_rdy_i,
  output ctrl_t       ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    case (state_i)
      S_IF: begin
        ctrl_o.mem_read  = 1'b1;
        ctrl_o.ir_write  = mem_rdy_i;
        ctrl_o.pc_write  = mem_rdy_i;
        ctrl_o.alu_src_b = SRCB_FOUR;
        ctrl_o.alu_op    = ALU_ADD;
        ctrl_o.pc_source = PCSRC_ALU;
      end
      S_ID: begin
        ctrl_o.alu_src_b = SRCB_IMM_SH;
        ctrl_o.alu_op    = ALU_ADD;
      end
      S_MADDR: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
        ctrl_o.alu_op    = ALU_ADD;
      end
      S_MRD: begin
        ctrl_o.mem_read = 1'b1;
        ctrl_o.i_or_d   = 1'b1;
      end
      S_MWB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
      end
      S_MWR: begin
        ctrl_o.mem_write = 1'b1;
        ctrl_o.i_or_d    = 1'b1;
      end
      S_REX: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_RT;
        ctrl_o.alu_op    = ALU_FUNCT;
      end
      S_RWB: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.reg_dst   = 1'b1;
      end
      S_IEX: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
        ctrl_o.alu_op    = (opcode_i == OP_SLTI) ? ALU_SLT : ALU_ADD;
      end
      S_IWB: ctrl_o.reg_write = 1'b1;
      S_BR: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_RT;
        ctrl_o.alu_op    = ALU_SUB;
        ctrl_o.pc_source = PCSRC_ALUOUT;
        // bne takes the branch on a nonzero difference
        ctrl_o.pc_write  = (opcode_i == OP_BNE) ? ~zero_i : zero_i;
      end
      S_JMP: begin
        ctrl_o.pc_write  = 1'b1;
        ctrl_o.pc_source = PCSRC_JUMP;
      end
      S_ILL: ctrl_o.illegal = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS main control: state register, next-state logic and the
// retired-instruction counter; output decode lives in multicycle_ctrl_decode.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int MEM_HANDSHAKE = 1,
  parameter int CNT_W         = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [5:0]       opcode_i,
  input  logic [5:0]       funct_i,
  input  logic             zero_i,
  input  logic             mem_ready_i,
  output logic             pc_write_o,
  output logic             i_or_d_o,
  output logic             mem_read_o,
  output logic             mem_write_o,
  output logic             ir_write_o,
  output logic             mem_to_reg_o,
  output logic             reg_dst_o,
  output logic             reg_write_o,
  output logic             alu_src_a_o,
  output logic [1:0]       alu_src_b_o,
  output logic [2:0]       alu_op_o,
  output logic [1:0]       pc_source_o,
  output logic             illegal_o,
  output logic [3:0]       state_o,
  output logic [CNT_W-1:0] retired_o
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             mem_rdy;
  logic             retire;
  ctrl_t            ctrl;
  logic             unused_funct;

  assign unused_funct = ^funct_i;
  assign mem_rdy      = (MEM_HANDSHAKE == 0) ? 1'b1 : mem_ready_i;

  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    case (state_q)
      S_IDLE:  state_d = S_IF;
      S_IF:    if (mem_rdy) state_d = S_ID;
      S_ID:    state_d = id_dispatch(opcode_i);
      S_MADDR: state_d = (opcode_i == OP_LW) ? S_MRD : S_MWR;
      S_MRD:   if (mem_rdy) state_d = S_MWB;
      S_MWR: begin
        if (mem_rdy) begin
          state_d = S_IF;
          retire  = 1'b1;
        end
      end
      S_REX:   state_d = S_RWB;
      S_IEX:   state_d = S_IWB;
      S_MWB, S_RWB, S_IWB, S_BR, S_JMP: begin
        state_d = S_IF;
        retire  = 1'b1;
      end
      S_ILL:   state_d = S_IF;
      default: state_d = S_IDLE;
    endcase
    retired_d = retire ? retired_q + {{(CNT_W-1){1'b0}}, 1'b1} : retired_q;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= S_IDLE;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  multicycle_ctrl_decode u_decode (
    .state_i   (state_q),
    .opcode_i  (opcode_i),
    .zero_i    (zero_i),
    .mem_rdy_i (mem_rdy),
    .ctrl_o    (ctrl)
  );

  assign pc_write_o   = ctrl.pc_write;
  assign i_or_d_o     = ctrl.i_or_d;
  assign mem_read_o   = ctrl.mem_read;
  assign mem_write_o  = ctrl.mem_write;
  assign ir_write_o   = ctrl.ir_write;
  assign mem_to_reg_o = ctrl.mem_to_reg;
  assign reg_dst_o    = ctrl.reg_dst;
  assign reg_write_o  = ctrl.reg_write;
  assign alu_src_a_o  = ctrl.alu_src_a;
  assign alu_src_b_o  = ctrl.alu_src_b;
  assign alu_op_o     = ctrl.alu_op;
  assign pc_source_o  = ctrl.pc_source;
  assign illegal_o    = ctrl.illegal;
  assign state_o      = state_q;
  assign retired_o    = retired_q;

endmodule
